// File: rtl/lcd_pkg.sv
// Shared types and default constants for the LCD test-pattern scheduler.
// State encoding and frame-count defaults used by frame-synchronous blocks.
package lcd_pkg;

  typedef enum logic [1:0] {
    PWRUP,
    AUTO,
    MANUAL
  } state_t;

  localparam int DEF_NUM_PATTERNS       = 8;
  localparam int DEF_FRAMES_PER_PATTERN = 60;
  localparam int DEF_BL_DELAY_FRAMES    = 4;

endpackage

// File: rtl/lcd_vs_edge.sv
// Vertical-sync edge detector producing a one-cycle registered frame tick.
// Same clock domain as the timing generator, so no synchronizer stage.
module lcd_vs_edge #(
  parameter bit VS_POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic lcd_vsync,
  output logic frame_tick
);

  logic vs_d;
  logic armed;
  logic act;
  logic vs_rise;

  assign act = (lcd_vsync == VS_POL);

  // armed blocks a tick from a vsync that was already active at reset exit
  assign vs_rise = act && (vs_d != VS_POL) && armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d       <= ~VS_POL;
      armed      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_d       <= lcd_vsync;
      armed      <= armed | ~act;
      frame_tick <= vs_rise;
    end
  end

endmodule

// File: rtl/lcd_pattern_sched.sv
// Frame-synchronous test-pattern scheduler with backlight power-up delay.
// Pattern changes are applied only on frame ticks, never mid-frame.
module lcd_pattern_sched
  import lcd_pkg::*;
#(
  parameter int NUM_PATTERNS       = DEF_NUM_PATTERNS,
  parameter int PAT_W              = 3,
  parameter int FRAMES_PER_PATTERN = DEF_FRAMES_PER_PATTERN,
  parameter int BL_DELAY_FRAMES    = DEF_BL_DELAY_FRAMES,
  parameter int CNT_W              = 8,
  parameter bit VS_POL             = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lcd_vsync,
  input  logic             auto_en,
  input  logic             btn_next,
  output logic [PAT_W-1:0] pattern_sel,
  output logic             pattern_chg,
  output logic             lcd_bl,
  output logic             frame_tick,
  output logic             busy_pwrup
);

  localparam logic [CNT_W-1:0] BL_LAST  = CNT_W'(BL_DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0] FPP_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [PAT_W-1:0] pat, pat_n;
  logic             pend, pend_n;
  logic             bl, bl_n;
  logic             chg;
  logic             tick;

  lcd_vs_edge #(
    .VS_POL(VS_POL)
  ) u_vs_edge (
    .clk       (clk),
    .rst       (rst),
    .lcd_vsync (lcd_vsync),
    .frame_tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PWRUP;
      cnt   <= '0;
      pat   <= '0;
      pend  <= 1'b0;
      bl    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pat   <= pat_n;
      pend  <= pend_n;
      bl    <= bl_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pat_n   = pat;
    pend_n  = pend;
    bl_n    = bl;
    chg     = 1'b0;
    unique case (state)
      PWRUP: begin
        if (tick) begin
          if (cnt == BL_LAST) begin
            bl_n    = 1'b1;
            cnt_n   = '0;
            state_n = auto_en ? AUTO : MANUAL;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      AUTO: begin
        if (tick) begin
          if (pend || cnt == FPP_LAST) begin
            pat_n  = (pat == PAT_LAST) ? '0 : pat + 1'b1;
            cnt_n  = '0;
            pend_n = 1'b0;
            chg    = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        // a press on the tick cycle is left for the following tick
        if (btn_next) pend_n = 1'b1;
        if (!auto_en) begin
          state_n = MANUAL;
          cnt_n   = '0;
        end
      end
      MANUAL: begin
        cnt_n = '0;
        if (tick && pend) begin
          pat_n  = (pat == PAT_LAST) ? '0 : pat + 1'b1;
          pend_n = 1'b0;
          chg    = 1'b1;
        end
        if (btn_next) pend_n = 1'b1;
        if (auto_en) state_n = AUTO;
      end
      default: state_n = PWRUP;
    endcase
  end

  assign pattern_sel = pat;
  assign pattern_chg = chg;
  assign lcd_bl      = bl;
  assign frame_tick  = tick;
  assign busy_pwrup  = (state == PWRUP);

endmodule

// File: tb/tb_lcd_pattern_sched.sv
// Bench for lcd_pattern_sched: directed scenarios plus a randomized run
// against a frame-level behavioural model of the scheduler.
module tb_lcd_pattern_sched;

  localparam int N  = 4;
  localparam int F  = 3;
  localparam int BL = 2;

  logic       clk;
  logic       rst;
  logic       lcd_vsync;
  logic       auto_en;
  logic       btn_next;
  logic [1:0] pattern_sel;
  logic       pattern_chg;
  logic       lcd_bl;
  logic       frame_tick;
  logic       busy_pwrup;

  int n_tests;
  int n_fail;
  int phase;
  bit g_ae;

  int m_prev;
  bit m_tick;
  bit m_on;
  bit m_auto;
  int m_cnt;
  bit m_pend;
  int m_pat;
  bit m_bl;

  lcd_pattern_sched #(
    .NUM_PATTERNS      (N),
    .PAT_W             (2),
    .FRAMES_PER_PATTERN(F),
    .BL_DELAY_FRAMES   (BL),
    .CNT_W             (8),
    .VS_POL            (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lcd_vsync  (lcd_vsync),
    .auto_en    (auto_en),
    .btn_next   (btn_next),
    .pattern_sel(pattern_sel),
    .pattern_chg(pattern_chg),
    .lcd_bl     (lcd_bl),
    .frame_tick (frame_tick),
    .busy_pwrup (busy_pwrup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_chg();
    return m_tick && m_on && (m_pend || (m_auto && m_cnt == F - 1));
  endfunction

  // vsync is active-low for the last 4 clocks of each 100-clock frame
  task automatic step(input bit r, input bit b);
    bit vs;
    bit rise;
    vs = (phase >= 96) ? 1'b0 : 1'b1;
    rst = r;
    lcd_vsync = vs;
    auto_en = g_ae;
    btn_next = b;
    if (r) begin
      m_prev = -1;
      m_tick = 0;
      m_on = 0;
      m_auto = 0;
      m_cnt = 0;
      m_pend = 0;
      m_pat = 0;
      m_bl = 0;
    end else begin
      rise = (vs == 1'b0) && (m_prev == 1);
      m_prev = vs;
      if (!m_on) begin
        if (m_tick) begin
          if (m_cnt == BL - 1) begin
            m_on = 1;
            m_bl = 1;
            m_cnt = 0;
            m_auto = g_ae;
          end else begin
            m_cnt++;
          end
        end
      end else begin
        if (m_tick) begin
          if (m_pend || (m_auto && m_cnt == F - 1)) begin
            m_pat = (m_pat + 1) % N;
            m_pend = 0;
            m_cnt = 0;
          end else if (m_auto) begin
            m_cnt++;
          end
        end
        if (b) m_pend = 1;
        if (m_auto != g_ae) begin
          m_auto = g_ae;
          m_cnt = 0;
        end
      end
      m_tick = rise;
    end
    phase = (phase + 1) % 100;
    @(negedge clk);
  endtask

  task automatic to_tick();
    bit seen;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b0);
      if (frame_tick === 1'b1) begin
        seen = 1;
        break;
      end
    end
    n_tests++;
    if (!seen || m_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_wait: seen=%0d model_tick=%0d", seen, m_tick);
    end
  endtask

  task automatic test_reset();
    g_ae = 1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    n_tests++;
    if (pattern_sel !== 2'd0 || lcd_bl !== 1'b0 || busy_pwrup !== 1'b1 ||
        frame_tick !== 1'b0 || pattern_chg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: sel=%0d bl=%b busy=%b tick=%b chg=%b",
               pattern_sel, lcd_bl, busy_pwrup, frame_tick, pattern_chg);
    end
    phase = 0;
    to_tick();
    n_tests++;
    if (lcd_bl !== 1'b0 || busy_pwrup !== 1'b1) begin
      n_fail++;
      $display("FAIL pwrup_tick1: bl=%b busy=%b want 0 1", lcd_bl, busy_pwrup);
    end
    to_tick();
    n_tests++;
    if (lcd_bl !== 1'b0 || busy_pwrup !== 1'b1 || pattern_chg !== 1'b0) begin
      n_fail++;
      $display("FAIL pwrup_tick2: bl=%b busy=%b chg=%b want 0 1 0",
               lcd_bl, busy_pwrup, pattern_chg);
    end
    step(1'b0, 1'b0);
    n_tests++;
    if (lcd_bl !== 1'b1 || busy_pwrup !== 1'b0 || pattern_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL pwrup_done: bl=%b busy=%b sel=%0d want 1 0 0",
               lcd_bl, busy_pwrup, pattern_sel);
    end
  endtask

  task automatic test_auto();
    for (int k = 1; k <= 12; k++) begin
      to_tick();
      n_tests++;
      if (pattern_chg !== (k % 3 == 0)) begin
        n_fail++;
        $display("FAIL auto_chg: tick=%0d chg=%b want %0d",
                 k, pattern_chg, (k % 3 == 0));
      end
      step(1'b0, 1'b0);
      n_tests++;
      if (pattern_sel !== (k / 3) % 4 || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL auto_sel: tick=%0d sel=%0d want %0d tick_out=%b",
                 k, pattern_sel, (k / 3) % 4, frame_tick);
      end
    end
  endtask

  task automatic test_manual_collapse();
    g_ae = 0;
    repeat (5) step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat (8) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end
    step(1'b0, 1'b0);
    n_tests++;
    if (pattern_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL man_early: sel=%0d want 0", pattern_sel);
    end
    to_tick();
    n_tests++;
    if (pattern_chg !== 1'b1) begin
      n_fail++;
      $display("FAIL man_chg: chg=%b want 1", pattern_chg);
    end
    step(1'b0, 1'b0);
    n_tests++;
    if (pattern_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL man_sel: sel=%0d want 1", pattern_sel);
    end
    to_tick();
    step(1'b0, 1'b0);
    n_tests++;
    if (pattern_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL man_single: sel=%0d want 1", pattern_sel);
    end
  endtask

  task automatic test_btn_on_tick();
    to_tick();
    n_tests++;
    if (pattern_chg !== 1'b0) begin
      n_fail++;
      $display("FAIL bot_chg0: chg=%b want 0", pattern_chg);
    end
    step(1'b0, 1'b1);
    n_tests++;
    if (pattern_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL bot_hold: sel=%0d want 1", pattern_sel);
    end
    to_tick();
    n_tests++;
    if (pattern_chg !== 1'b1) begin
      n_fail++;
      $display("FAIL bot_chg1: chg=%b want 1", pattern_chg);
    end
    step(1'b0, 1'b0);
    n_tests++;
    if (pattern_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL bot_sel: sel=%0d want 2", pattern_sel);
    end
  endtask

  task automatic test_auto_btn();
    bit want [5];
    want = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    g_ae = 1;
    repeat (5) step(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        repeat (20) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
      end
      to_tick();
      n_tests++;
      if (pattern_chg !== want[k]) begin
        n_fail++;
        $display("FAIL ab_chg: tick=%0d chg=%b want %b",
                 k, pattern_chg, want[k]);
      end
    end
    step(1'b0, 1'b0);
    n_tests++;
    if (pattern_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL ab_sel: sel=%0d want 0", pattern_sel);
    end
  endtask

  task automatic test_mid_reset();
    repeat (6) to_tick();
    step(1'b0, 1'b0);
    n_tests++;
    if (pattern_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL mr_pre: sel=%0d want 2", pattern_sel);
    end
    repeat (30) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_tests++;
    if (pattern_sel !== 2'd0 || lcd_bl !== 1'b0 || busy_pwrup !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_reset: sel=%0d bl=%b busy=%b want 0 0 1",
               pattern_sel, lcd_bl, busy_pwrup);
    end
    to_tick();
    to_tick();
    n_tests++;
    if (lcd_bl !== 1'b0 || busy_pwrup !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_delay: bl=%b busy=%b want 0 1", lcd_bl, busy_pwrup);
    end
    step(1'b0, 1'b0);
    n_tests++;
    if (lcd_bl !== 1'b1 || busy_pwrup !== 1'b0 || pattern_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL mr_done: bl=%b busy=%b sel=%0d want 1 0 0",
               lcd_bl, busy_pwrup, pattern_sel);
    end
  endtask

  task automatic test_random();
    while (phase != 97) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(149) == 0) g_ae = ~g_ae;
      step(($urandom_range(699) == 0), ($urandom_range(39) == 0));
      n_tests++;
      if (pattern_sel !== m_pat || pattern_chg !== m_chg() ||
          lcd_bl !== m_bl || frame_tick !== m_tick ||
          busy_pwrup !== !m_on) begin
        n_fail++;
        $display("FAIL rand_cyc%0d: sel=%0d/%0d chg=%b/%b bl=%b/%b tick=%b/%b busy=%b/%b",
                 i, pattern_sel, m_pat, pattern_chg, m_chg(), lcd_bl, m_bl,
                 frame_tick, m_tick, busy_pwrup, !m_on);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    phase = 0;
    g_ae = 1;
    rst = 1'b1;
    lcd_vsync = 1'b1;
    auto_en = 1'b1;
    btn_next = 1'b0;
    @(negedge clk);
    test_reset();
    test_auto();
    test_manual_collapse();
    test_btn_on_tick();
    test_auto_btn();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
